// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel timer: channel FSM states and mode values.
package timer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: FSM, count/reload registers and expiry pulse.
// TIMER_WARN_EN adds a registered pre-expiry warning output.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 8
`ifdef TIMER_WARN_EN
    ,
    parameter int unsigned WARN_CNT = 3
`endif
) (
    input  logic             clock,
    input  logic             Reset_Sync,
    input  logic             tick,
    input  logic             start,
    input  logic [CNT_W-1:0] value,
    input  logic             mode,
    input  logic             pause,
    output logic             expired,
    output logic             running,
    output logic [CNT_W-1:0] remaining
`ifdef TIMER_WARN_EN
    ,
    output logic             warning
`endif
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (start) begin
            count_d  = value;
            reload_d = value;
            state_d  = pause ? ST_PAUSED : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (count_q == '0) begin
                        // Zero load: fire once and stop, even in periodic mode.
                        expired_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (tick) begin
                        if (count_q == CNT_W'(1)) begin
                            expired_d = 1'b1;
                            if (mode == MODE_PERIODIC) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = count_q - CNT_W'(1);
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset_Sync) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign expired   = expired_q;
    assign running   = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign remaining = count_q;

`ifdef TIMER_WARN_EN
    logic warning_q, warning_d;

    // Computed from next-state values so it lines up with remaining.
    assign warning_d = ((state_d == ST_RUN) || (state_d == ST_PAUSED)) &&
                       (count_d != '0) && (count_d <= CNT_W'(WARN_CNT));

    always_ff @(posedge clock) begin
        if (!Reset_Sync) begin
            warning_q <= 1'b0;
        end else begin
            warning_q <= warning_d;
        end
    end

    assign warning = warning_q;
`endif

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH independent down-counting timers sharing a 1 Hz tick edge detector.
// TIMER_WARN_EN adds the per-channel Warning output.
module multi_channel_timer #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned WARN_CNT = 3
) (
    input  logic                    clock,
    input  logic                    Reset_Sync,
    input  logic                    Hz_1_Enable,
    input  logic [NUM_CH-1:0]       Start_Timer,
    input  logic [NUM_CH*CNT_W-1:0] Value,
    input  logic [NUM_CH-1:0]       Mode,
    input  logic [NUM_CH-1:0]       Pause,
    output logic [NUM_CH-1:0]       Expired,
    output logic [NUM_CH-1:0]       Running,
`ifdef TIMER_WARN_EN
    output logic [NUM_CH-1:0]       Warning,
`endif
    output logic [NUM_CH*CNT_W-1:0] Remaining
);

    logic hz_q;
    logic tick;

    always_ff @(posedge clock) begin
        if (!Reset_Sync) begin
            hz_q <= 1'b0;
        end else begin
            hz_q <= Hz_1_Enable;
        end
    end

    assign tick = Hz_1_Enable & ~hz_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef TIMER_WARN_EN
        timer_channel #(
            .CNT_W   (CNT_W),
            .WARN_CNT(WARN_CNT)
        ) u_ch (
            .clock     (clock),
            .Reset_Sync(Reset_Sync),
            .tick      (tick),
            .start     (Start_Timer[i]),
            .value     (Value[i*CNT_W +: CNT_W]),
            .mode      (Mode[i]),
            .pause     (Pause[i]),
            .expired   (Expired[i]),
            .running   (Running[i]),
            .remaining (Remaining[i*CNT_W +: CNT_W]),
            .warning   (Warning[i])
        );
`else
        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clock     (clock),
            .Reset_Sync(Reset_Sync),
            .tick      (tick),
            .start     (Start_Timer[i]),
            .value     (Value[i*CNT_W +: CNT_W]),
            .mode      (Mode[i]),
            .pause     (Pause[i]),
            .expired   (Expired[i]),
            .running   (Running[i]),
            .remaining (Remaining[i*CNT_W +: CNT_W])
        );
`endif
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer (default CNT_W=8, NUM_CH=2).
module tb_multi_channel_timer;

    localparam int CNT_W  = 8;
    localparam int NUM_CH = 2;

    logic                    clock = 1'b0;
    logic                    Reset_Sync;
    logic                    Hz_1_Enable;
    logic [NUM_CH-1:0]       Start_Timer;
    logic [NUM_CH*CNT_W-1:0] Value;
    logic [NUM_CH-1:0]       Mode;
    logic [NUM_CH-1:0]       Pause;
    logic [NUM_CH-1:0]       Expired;
    logic [NUM_CH-1:0]       Running;
    logic [NUM_CH*CNT_W-1:0] Remaining;
`ifdef TIMER_WARN_EN
    logic [NUM_CH-1:0]       Warning;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt[NUM_CH] = '{0, 0};
    int exp_both = 0;

    typedef struct {
        logic [CNT_W-1:0] rem;
        int               exps;
        logic             warn;
    } exp_t;
    exp_t sb[$];

    multi_channel_timer #(
        .CNT_W   (CNT_W),
        .NUM_CH  (NUM_CH),
        .WARN_CNT(3)
    ) dut (
        .clock      (clock),
        .Reset_Sync (Reset_Sync),
        .Hz_1_Enable(Hz_1_Enable),
        .Start_Timer(Start_Timer),
        .Value      (Value),
        .Mode       (Mode),
        .Pause      (Pause),
        .Expired    (Expired),
        .Running    (Running),
`ifdef TIMER_WARN_EN
        .Warning    (Warning),
`endif
        .Remaining  (Remaining)
    );

    always #5 clock = ~clock;

    // Records every clock that Expired is high, per channel.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Expired[i] === 1'b1) exp_cnt[i]++;
        end
        if (Expired === 2'b11) exp_both++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "timeout");
    end

    function automatic logic [CNT_W-1:0] rem_of(input int ch);
        return Remaining[ch*CNT_W +: CNT_W];
    endfunction

    // One rising edge on the 1 Hz enable, level held for two clocks.
    task automatic do_tick();
        @(negedge clock) Hz_1_Enable = 1'b1;
        @(negedge clock);
        @(negedge clock) Hz_1_Enable = 1'b0;
        @(negedge clock);
    endtask

    task automatic apply_start(input int ch, input logic [CNT_W-1:0] v, input logic m,
                               input logic p);
        @(negedge clock);
        Start_Timer[ch] = 1'b1;
        Value[ch*CNT_W +: CNT_W] = v;
        Mode[ch]  = m;
        Pause[ch] = p;
        @(negedge clock);
        Start_Timer[ch] = 1'b0;
    endtask

    task automatic test_reset();
        int base0;
        int base1;
        Reset_Sync  = 1'b0;
        Hz_1_Enable = 1'b0;
        Start_Timer = '1;
        Value       = {8'd5, 8'd5};
        Mode        = '0;
        Pause       = '0;
        repeat (2) @(negedge clock);
        base0 = exp_cnt[0];
        base1 = exp_cnt[1];
        for (int k = 0; k < 3; k++) begin
            do_tick();
            n_checks++;
            if (Expired !== 2'b00 || Running !== 2'b00 || Remaining !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: Expired=%b Running=%b Remaining=%h, required 00 00 0000",
                         Expired, Running, Remaining);
            end
        end
        n_checks++;
        if (exp_cnt[0] != base0 || exp_cnt[1] != base1) begin
            n_fail++;
            $display("FAIL reset_no_pulse: expiry pulses %0d/%0d, required 0/0",
                     exp_cnt[0] - base0, exp_cnt[1] - base1);
        end
        Start_Timer = '0;
        @(negedge clock) Reset_Sync = 1'b1;
        apply_start(0, 8'd5, 1'b0, 1'b0);
        do_tick();
        do_tick();
        n_checks++;
        if (rem_of(0) !== 8'd3) begin
            n_fail++;
            $display("FAIL reset_precount: Remaining=%0d, required 3", rem_of(0));
        end
        Reset_Sync = 1'b0;
        @(negedge clock);
        n_checks++;
        if (rem_of(0) !== 8'd0 || Running[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midcount: Remaining=%0d Running=%b, required 0 0",
                     rem_of(0), Running[0]);
        end
        Reset_Sync = 1'b1;
    endtask

    task automatic test_one_shot();
        exp_t e;
        int   base;
        base = exp_cnt[0];
        apply_start(0, 8'd5, 1'b0, 1'b0);
        sb.push_back('{rem: 8'd5, exps: 0, warn: 1'b0});
        e = sb.pop_front();
        n_checks++;
        if (rem_of(0) !== e.rem || Running[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_load: Remaining=%0d Running=%b, required %0d 1",
                     rem_of(0), Running[0], e.rem);
        end
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{rem: 8'(5 - k), exps: (k == 5) ? 1 : 0, warn: 1'b0});
            do_tick();
            e = sb.pop_front();
            n_checks++;
            if (rem_of(0) !== e.rem || exp_cnt[0] - base != e.exps) begin
                n_fail++;
                $display("FAIL oneshot_tick%0d: Remaining=%0d pulses=%0d, required %0d %0d",
                         k, rem_of(0), exp_cnt[0] - base, e.rem, e.exps);
            end
        end
        n_checks++;
        if (Running[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_done: Running=%b, required 0", Running[0]);
        end
    endtask

    task automatic test_periodic();
        exp_t e;
        int   base;
        base = exp_cnt[1];
        apply_start(1, 8'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            sb.push_back('{rem: 8'(3 - (k % 3)), exps: k / 3, warn: 1'b0});
            do_tick();
            e = sb.pop_front();
            n_checks++;
            if (rem_of(1) !== e.rem || exp_cnt[1] - base != e.exps) begin
                n_fail++;
                $display("FAIL periodic_tick%0d: Remaining=%0d pulses=%0d, required %0d %0d",
                         k, rem_of(1), exp_cnt[1] - base, e.rem, e.exps);
            end
        end
        n_checks++;
        if (Running[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_running: Running=%b, required 1", Running[1]);
        end
        // Mode is sampled at expiry: switching to one-shot ends the next period.
        Mode[1] = 1'b0;
        repeat (3) do_tick();
        n_checks++;
        if (exp_cnt[1] - base != 5 || Running[1] !== 1'b0 || rem_of(1) !== 8'd0) begin
            n_fail++;
            $display("FAIL periodic_to_oneshot: pulses=%0d Running=%b Remaining=%0d, required 5 0 0",
                     exp_cnt[1] - base, Running[1], rem_of(1));
        end
    endtask

    task automatic test_level_tick();
        apply_start(0, 8'd10, 1'b0, 1'b0);
        @(negedge clock) Hz_1_Enable = 1'b1;
        repeat (5) @(negedge clock);
        Hz_1_Enable = 1'b0;
        @(negedge clock);
        n_checks++;
        if (rem_of(0) !== 8'd9) begin
            n_fail++;
            $display("FAIL level_tick: Remaining=%0d, required 9", rem_of(0));
        end
    endtask

    task automatic test_pause();
        exp_t e;
        int   base;
        base = exp_cnt[0];
        apply_start(0, 8'd4, 1'b0, 1'b0);
        // Pause arrives together with a tick edge; the tick must be lost.
        @(negedge clock);
        Pause[0]    = 1'b1;
        Hz_1_Enable = 1'b1;
        @(negedge clock) Hz_1_Enable = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rem_of(0) !== 8'd4 || Running[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL pause_hold%0d: Remaining=%0d Running=%b, required 4 1",
                         k, rem_of(0), Running[0]);
            end
            if (k < 3) do_tick();
        end
        @(negedge clock) Pause[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sb.push_back('{rem: 8'(4 - k), exps: (k == 4) ? 1 : 0, warn: 1'b0});
            do_tick();
            e = sb.pop_front();
            n_checks++;
            if (rem_of(0) !== e.rem || exp_cnt[0] - base != e.exps) begin
                n_fail++;
                $display("FAIL pause_resume%0d: Remaining=%0d pulses=%0d, required %0d %0d",
                         k, rem_of(0), exp_cnt[0] - base, e.rem, e.exps);
            end
        end
        n_checks++;
        if (Running[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_done: Running=%b, required 0", Running[0]);
        end
    endtask

    task automatic test_collision();
        @(negedge clock);
        Start_Timer[0] = 1'b1;
        Value[7:0]     = 8'd7;
        Mode[0]        = 1'b0;
        Pause[0]       = 1'b0;
        Hz_1_Enable    = 1'b1;
        @(negedge clock) Start_Timer[0] = 1'b0;
        @(negedge clock) Hz_1_Enable = 1'b0;
        @(negedge clock);
        n_checks++;
        if (rem_of(0) !== 8'd7) begin
            n_fail++;
            $display("FAIL collision_load: Remaining=%0d, required 7", rem_of(0));
        end
        do_tick();
        n_checks++;
        if (rem_of(0) !== 8'd6) begin
            n_fail++;
            $display("FAIL collision_next_tick: Remaining=%0d, required 6", rem_of(0));
        end
    endtask

    task automatic test_zero_load();
        int base;
        base = exp_cnt[0];
        apply_start(0, 8'd0, 1'b1, 1'b0);
        @(negedge clock);
        n_checks++;
        if (Expired[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_pulse: Expired=%b, required 1", Expired[0]);
        end
        @(negedge clock);
        n_checks++;
        if (Expired[0] !== 1'b0 || Running[0] !== 1'b0 || rem_of(0) !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_done: Expired=%b Running=%b Remaining=%0d, required 0 0 0",
                     Expired[0], Running[0], rem_of(0));
        end
        do_tick();
        do_tick();
        n_checks++;
        if (exp_cnt[0] - base != 1) begin
            n_fail++;
            $display("FAIL zero_single: pulses=%0d, required 1", exp_cnt[0] - base);
        end
    endtask

    task automatic test_back_to_back();
        int base0;
        int base1;
        int both;
        @(negedge clock);
        Start_Timer = 2'b11;
        Value       = {8'd2, 8'd2};
        Mode        = 2'b00;
        Pause       = 2'b00;
        @(negedge clock) Start_Timer = 2'b00;
        base0 = exp_cnt[0];
        base1 = exp_cnt[1];
        both  = exp_both;
        do_tick();
        do_tick();
        n_checks++;
        if (exp_cnt[0] - base0 != 1 || exp_cnt[1] - base1 != 1 || exp_both - both != 1) begin
            n_fail++;
            $display("FAIL simultaneous: pulses=%0d/%0d together=%0d, required 1/1 1",
                     exp_cnt[0] - base0, exp_cnt[1] - base1, exp_both - both);
        end
    endtask

`ifdef TIMER_WARN_EN
    task automatic test_warning();
        exp_t e;
        apply_start(0, 8'd6, 1'b0, 1'b0);
        n_checks++;
        if (Warning[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL warn_load: Warning=%b, required 0", Warning[0]);
        end
        for (int k = 1; k <= 6; k++) begin
            sb.push_back('{rem: 8'(6 - k), exps: 0, warn: ((6 - k) >= 1) && ((6 - k) <= 3)});
            do_tick();
            e = sb.pop_front();
            n_checks++;
            if (rem_of(0) !== e.rem || Warning[0] !== e.warn) begin
                n_fail++;
                $display("FAIL warn_tick%0d: Remaining=%0d Warning=%b, required %0d %b",
                         k, rem_of(0), Warning[0], e.rem, e.warn);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_level_tick();
        test_pause();
        test_collision();
        test_zero_load();
        test_back_to_back();
`ifdef TIMER_WARN_EN
        test_warning();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_timer.md
Name: multi_channel_timer

Overview:
- Parametrised successor to the single 4-bit traffic-light timer. Provides NUM_CH independent down-counting channels of CNT_W bits, clocked by the system clock and advanced by a shared 1 Hz enable.
- Each channel adds one-shot and periodic modes, pause/resume, a remaining-count readback and a running flag.
- Sits between the controller FSM and the 1 Hz prescaler. Lets one instance time several phases, e.g. main green plus pedestrian walk.

Parameters:
- CNT_W, 8, counter/load width per channel (min 2)
- NUM_CH, 2, number of independent channels (min 1)
- WARN_CNT, 3, warning threshold; used only with TIMER_WARN_EN

Ports:
- clock  in  1  system clock, all logic on rising edge
- Reset_Sync  in  1  synchronous, active-low reset, sampled on clock rising edge
- Hz_1_Enable  in  1  1 Hz timebase, multi-cycle level; rising edge detected internally
- Start_Timer  in  NUM_CH  per-channel level start/load
- Value  in  NUM_CH*CNT_W  per-channel load value; channel i uses bits [i*CNT_W +: CNT_W]
- Mode  in  NUM_CH  per channel: 0 = one-shot, 1 = periodic
- Pause  in  NUM_CH  per-channel pause level
- Expired  out  NUM_CH  one-clock expiry pulse per channel
- Running  out  NUM_CH  channel in RUN or PAUSED
- Remaining  out  NUM_CH*CNT_W  current count per channel

Behaviour:
- Tick generation:
  - tick = Hz_1_Enable & ~hz_q, where hz_q is a registered copy of Hz_1_Enable.
  - One tick per 1 Hz period, shared by all channels.
- Reset (Reset_Sync == 0 at a clock edge):
  - hz_q = 0; every channel goes to IDLE.
  - count = 0, reload = 0, Expired = 0, Running = 0, Remaining = 0.
  - Reset overrides all other inputs, including a reset asserted mid-count.
- Per-channel states: IDLE, RUN, PAUSED, DONE.
- Start_Timer[i] high, from any state:
  - Each cycle it is held: count <= Value_i and reload <= Value_i.
  - State becomes RUN, or PAUSED if Pause[i] = 1.
  - Ticks are ignored while Start is held; counting begins on the first tick after Start falls.
  - Start beats a simultaneous tick.
- Decrement: in RUN with a tick and no Start, count <= count - 1.
- Expiry (tick arrives with count == 1):
  - count <= 0 and Expired[i] = 1 for exactly the next clock.
  - Expiry therefore occurs Value ticks after Start falls.
- After expiry:
  - Mode 0 (one-shot): go to DONE, Running = 0, count stays 0.
  - Mode 1 (periodic): count <= reload, stay in RUN with no dead tick. Periods are exactly reload ticks.
  - Mode is sampled at expiry, not at Start.
- Value 0 loaded:
  - Expired pulses once, one clock after Start falls, then the channel goes to DONE regardless of Mode.
  - This prevents free-running pulsing.
- Pause:
  - RUN with Pause = 1 goes to PAUSED; ticks are ignored and count is held.
  - PAUSED with Pause = 0 returns to RUN.
  - Pause and tick in the same cycle: the tick is ignored.
  - Pause has no effect in IDLE or DONE.
- IDLE/DONE: ticks are ignored; only Start leaves these states.
- Outputs:
  - Running = (state == RUN) | (state == PAUSED).
  - Remaining = count, registered.
  - Expired is registered; no combinational input-to-output paths.
- Width rules:
  - Value is treated as unsigned.
  - count never wraps below 0, because the decrement is suppressed at 0.
  - Maximum period is 2^CNT_W - 1 ticks.
- Channels are fully independent. Simultaneous expiries on different channels each pulse in the same cycle.

Optional Feature:
- Macro: TIMER_WARN_EN.
- Defined:
  - Adds output Warning [NUM_CH], registered.
  - Warning[i] = 1 while state is RUN or PAUSED and 0 < count <= WARN_CNT; reset value 0.
  - Used to drive amber pre-warning.
- Undefined:
  - No Warning port and no WARN_CNT comparison logic.
  - All other behaviour is identical.

Decomposition:
- Package/include timer_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSED=2'd2, ST_DONE=2'd3
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1
- Sub-module timer_channel holds one channel: FSM, count, reload, Expired, Warning.
  - Ports: clock, Reset_Sync, tick, start, value, mode, pause, expired, running, remaining.
- Top contains the tick edge detector and a generate loop of NUM_CH timer_channel instances.

Test Plan:
- Reset: hold Reset_Sync = 0 with Start = 1 and ticks present -> Expired = 0, Running = 0, Remaining = 0 throughout. Assert Reset_Sync = 0 mid-count at Remaining = 3 -> IDLE and Remaining = 0 on the next edge.
- One-shot: ch0, Value = 5, Mode = 0, Start high for 1 cycle -> Remaining steps 5,4,3,2,1,0 on successive ticks. Expired[0] is high for exactly one clock after the 5th tick, then Running = 0.
- Periodic: ch1, Value = 3, Mode = 1 -> Expired[1] pulses every 3 ticks, 4 consecutive times. Remaining reloads 3 with no skipped tick.
- Pause and level-tick:
  - Hold Hz_1_Enable high for 5 clocks -> exactly one decrement.
  - ch0 at Remaining = 4, Pause high across 3 ticks -> stays 4 and Running = 1. After release it resumes and expires 4 ticks later.
- Start/tick collision and zero load:
  - Start and tick in the same cycle -> Remaining = Value, no decrement.
  - Value = 0 -> single Expired pulse, then DONE even with Mode = 1.
- TIMER_WARN_EN: WARN_CNT = 3, Value = 6 -> Warning rises when Remaining = 3 and falls when Remaining reaches 0. Without the macro, the Warning port is absent.
